// File: rtl/mode7_stepper.sv
// mode7_stepper: per-pixel affine texture-coordinate generator (SNES
// "mode 7" style rotate/scale) driven by a VGA-style pixel timebase.
//
// Frame parameters are taken into shadow registers once per frame, at the
// start of vertical blank. The sin/cos values for the shadow angle come
// from an external ROM with one clock of latency. On each line's HACT tick
// a short setup sequence builds the start-of-line accumulators with one
// shared multiplier. During the active pixels the accumulators then step
// by (du, dv).
//
// Ports:
//   clk, reset (async, active low)
//   p_tick, video_on, pixel_x, pixel_y     timing from vga_sync
//   originx/y, offsetx/y, scalex/y, angle, tex_mask   per-frame parameters
//   rom_addr -> / rom_cos, rom_sin <-      sin/cos ROM (Q2.14, 1 clk latency)
//   tex_u, tex_v, tex_valid                registered coordinate out
module mode7_stepper #(
  parameter int HACT = 640,
  parameter int VACT = 480,
  parameter int VTOT = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [15:0] originx,
  input  logic [15:0] originy,
  input  logic [15:0] offsetx,
  input  logic [15:0] offsety,
  input  logic [23:0] scalex,
  input  logic [23:0] scaley,
  input  logic [8:0]  angle,
  input  logic [15:0] tex_mask,
  output logic [8:0]  rom_addr,
  input  logic [15:0] rom_cos,
  input  logic [15:0] rom_sin,
  output logic [15:0] tex_u,
  output logic [15:0] tex_v,
  output logic        tex_valid
);

  localparam logic [9:0] X_END  = 10'(HACT);
  localparam logic [9:0] Y_ACT  = 10'(VACT);
  localparam logic [9:0] Y_LAST = 10'(VTOT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, RUN} state_t;

  // ---------------- shadow registers + trig capture ----------------
  logic [15:0]        sh_orgx, sh_orgy, sh_offx, sh_offy, sh_mask;
  logic [23:0]        sh_sclx, sh_scly;
  logic [8:0]         sh_ang;
  logic [1:0]         ld_pipe;
  logic signed [15:0] cap_cos, cap_sin;
  logic               shadow_ld;

  assign shadow_ld = p_tick && (pixel_x == '0) && (pixel_y == Y_ACT);
  assign rom_addr  = sh_ang;

  // The ROM sees the new angle right after the load. Its data is valid one
  // clk later, so it is captured on the second edge after the load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_orgx <= '0;
      sh_orgy <= '0;
      sh_offx <= '0;
      sh_offy <= '0;
      sh_sclx <= 24'h000100;
      sh_scly <= 24'h000100;
      sh_ang  <= '0;
      sh_mask <= 16'hFFFF;
      ld_pipe <= '0;
      cap_cos <= 16'sd16384;
      cap_sin <= '0;
    end else begin
      ld_pipe <= {ld_pipe[0], shadow_ld};
      if (shadow_ld) begin
        sh_orgx <= originx;
        sh_orgy <= originy;
        sh_offx <= offsetx;
        sh_offy <= offsety;
        sh_sclx <= scalex;
        sh_scly <= scaley;
        sh_ang  <= angle;
        sh_mask <= tex_mask;
      end
      if (ld_pipe[1]) begin
        cap_cos <= rom_cos;
        cap_sin <= rom_sin;
      end
    end
  end

  // ---------------- line stepper ----------------
  state_t             state;
  logic [2:0]         step;
  logic signed [15:0] w_cos, w_sin;
  logic [23:0]        w_sclx, w_scly;
  logic [15:0]        w_offx, w_offy, w_mask;
  logic signed [16:0] dx0, dy;
  logic signed [39:0] du, su, dv, cv;
  logic signed [47:0] acc_u, acc_v;

  logic               line_end, present;
  logic [9:0]         ny;
  logic signed [39:0] mul_a;
  logic signed [24:0] mul_b;
  logic signed [47:0] mul_p;

  assign line_end = p_tick && (pixel_x == X_END);
  assign ny       = (pixel_y == Y_LAST) ? 10'd0 : pixel_y + 10'd1;
  // Pixel 0 arrives while still in WAIT, so it is presented on the same
  // tick that enters RUN.
  assign present  = p_tick && video_on && !line_end &&
                    ((state == RUN) || ((state == WAIT) && (pixel_x == '0)));

  // Shared multiplier. Only the low 48 bits are ever used, and in two's
  // complement those bits do not depend on the operand bits above 48.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (step)
      3'd0: begin mul_a = 40'(w_cos); mul_b = {1'b0, w_sclx}; end
      3'd1: begin mul_a = 40'(w_sin); mul_b = {1'b0, w_sclx}; end
      3'd2: begin mul_a = 40'(w_sin); mul_b = {1'b0, w_scly}; end
      3'd3: begin mul_a = 40'(w_cos); mul_b = {1'b0, w_scly}; end
      3'd4: begin mul_a = du;         mul_b = 25'(dx0);       end
      3'd5: begin mul_a = su;         mul_b = 25'(dy);        end
      3'd6: begin mul_a = dv;         mul_b = 25'(dx0);       end
      default: begin mul_a = cv;      mul_b = 25'(dy);        end
    endcase
    mul_p = 48'(mul_a) * 48'(mul_b);
  end

  // The working copies are taken at each HACT tick. A shadow load that
  // lands while SETUP is in progress therefore only affects the next line
  // setup.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      step      <= '0;
      w_cos     <= 16'sd16384;
      w_sin     <= '0;
      w_sclx    <= 24'h000100;
      w_scly    <= 24'h000100;
      w_offx    <= '0;
      w_offy    <= '0;
      w_mask    <= 16'hFFFF;
      dx0       <= '0;
      dy        <= '0;
      du        <= '0;
      su        <= '0;
      dv        <= '0;
      cv        <= '0;
      acc_u     <= '0;
      acc_v     <= '0;
      tex_u     <= '0;
      tex_v     <= '0;
      tex_valid <= 1'b0;
    end else begin
      tex_valid <= 1'b0;
      if (line_end) begin
        // Takes priority in every state, which also restarts a running SETUP.
        w_cos  <= cap_cos;
        w_sin  <= cap_sin;
        w_sclx <= sh_sclx;
        w_scly <= sh_scly;
        w_offx <= sh_offx;
        w_offy <= sh_offy;
        w_mask <= sh_mask;
        dx0    <= 17'd0 - {1'b0, sh_orgx};
        dy     <= {7'd0, ny} - {1'b0, sh_orgy};
        step   <= '0;
        state  <= (ny >= Y_ACT) ? WAIT : SETUP;
      end else if (present) begin
        tex_u     <= (acc_u[37:22] + w_offx) & w_mask;
        tex_v     <= (acc_v[37:22] + w_offy) & w_mask;
        tex_valid <= 1'b1;
        acc_u     <= acc_u + 48'(du);
        acc_v     <= acc_v + 48'(dv);
        state     <= RUN;
      end else begin
        case (state)
          SETUP: begin
            step <= step + 3'd1;
            case (step)
              3'd0: du    <= mul_p[39:0];
              3'd1: su    <= mul_p[39:0];
              3'd2: dv    <= mul_p[39:0];
              3'd3: cv    <= mul_p[39:0];
              3'd4: acc_u <= mul_p;
              3'd5: acc_u <= acc_u - mul_p;
              3'd6: acc_v <= mul_p;
              default: begin
                acc_v <= acc_v + mul_p;
                state <= WAIT;
              end
            endcase
          end
          RUN: if (p_tick && !video_on) state <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mode7_stepper.sv
// Directed bench for mode7_stepper: drives pixel timing by hand (lines may be
// partial; the stepper only reacts to x==0 / x==HACT events) and models the
// sin/cos ROM for angles 0 and 90.
module tb_mode7_stepper;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick, video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic [15:0] originx, originy, offsetx, offsety, tex_mask;
  logic [23:0] scalex, scaley;
  logic [8:0]  angle, rom_addr;
  logic [15:0] rom_cos = 16'd16384;
  logic [15:0] rom_sin = 16'd0;
  logic [15:0] tex_u, tex_v;
  logic        tex_valid;

  int n_vec = 0, n_err = 0;
  int vcnt = 0, bad_blank = 0, bad_gap = 0;

  always #5 clk = ~clk;

  mode7_stepper #(.HACT(640), .VACT(480), .VTOT(525)) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .originx(originx), .originy(originy), .offsetx(offsetx), .offsety(offsety),
    .scalex(scalex), .scaley(scaley), .angle(angle), .tex_mask(tex_mask),
    .rom_addr(rom_addr), .rom_cos(rom_cos), .rom_sin(rom_sin),
    .tex_u(tex_u), .tex_v(tex_v), .tex_valid(tex_valid)
  );

  // sin/cos ROM, Q2.14, one clock latency
  always @(posedge clk) begin
    if (rom_addr == 9'd90) begin
      rom_cos <= 16'd0;
      rom_sin <= 16'd16384;
    end else begin
      rom_cos <= 16'd16384;
      rom_sin <= 16'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // One p_tick clock followed by one quiet clock; sampled 1ns after each edge.
  task automatic pix(input int x, input int y, input logic von);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    p_tick   = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0;
    if (tex_valid) begin
      vcnt++;
      if (!von) bad_blank++;
    end
    @(posedge clk); #1;
    if (tex_valid) bad_gap++;
  endtask

  task automatic active(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) pix(x, y, 1'b1);
  endtask

  // HACT tick of line y (sets up line y+1) plus time for the setup sequence
  task automatic hsync(input int y);
    pix(640, y, 1'b0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic load();
    pix(0, 480, 1'b0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    originx = 16'd33; originy = 16'd44; offsetx = 16'd5; offsety = 16'd6;
    scalex = 24'h000300; scaley = 24'h000300; angle = 9'd90; tex_mask = 16'h00F0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_u", tex_u, 0);
    chk("rst_v", tex_v, 0);
    chk("rst_valid", tex_valid, 0);
    chk("rst_rom_addr", rom_addr, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // identity
    angle = 9'd0; scalex = 24'h000100; scaley = 24'h000100;
    originx = 0; originy = 0; offsetx = 0; offsety = 0; tex_mask = 16'h00FF;
    load();
    hsync(4);
    vcnt = 0;
    active(5, 0, 300);
    chk("id_u", tex_u, 16'h2C);
    chk("id_v", tex_v, 16'h05);
    chk("id_cnt", vcnt, 301);

    // rotation 90 degrees about (320,240)
    angle = 9'd90; originx = 16'd320; originy = 16'd240; tex_mask = 16'hFFFF;
    load();
    chk("rot_rom_addr", rom_addr, 90);
    hsync(239);
    active(240, 0, 330);
    chk("rot_u_a", tex_u, 16'h0000);
    chk("rot_v_a", tex_v, 16'd10);
    hsync(249);
    active(250, 0, 320);
    chk("rot_u_b", tex_u, 16'hFFF6);
    chk("rot_v_b", tex_v, 16'h0000);

    // scale and offset
    angle = 9'd0; originx = 0; originy = 0;
    scalex = 24'h000200; scaley = 24'h000080; offsetx = 16'd7; offsety = 0;
    load();
    hsync(8);
    active(9, 0, 10);
    chk("sc_u", tex_u, 16'd27);
    chk("sc_v", tex_v, 16'd4);

    // second HACT tick during SETUP restarts it for the new line
    pix(640, 3, 1'b0);
    hsync(8);
    active(9, 0, 10);
    chk("restart_v", tex_v, 16'd4);

    // shadow load while SETUP runs: current line keeps the old parameters
    pix(640, 8, 1'b0);
    angle = 9'd90; offsetx = 16'd50;
    pix(0, 480, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    active(9, 0, 10);
    chk("ldsetup_u", tex_u, 16'd27);
    chk("ldsetup_v", tex_v, 16'd4);
    angle = 9'd0; offsetx = 16'd7;
    load();

    // offset changed mid-frame is ignored until the next frame
    hsync(99);
    active(100, 0, 10);
    chk("sh_u100", tex_u, 16'd27);
    offsetx = 16'd100;
    hsync(100);
    active(101, 0, 10);
    chk("sh_u101", tex_u, 16'd27);
    hsync(478);
    active(479, 0, 10);
    chk("sh_u479", tex_u, 16'd27);
    hsync(479);
    vcnt = 0;
    load();
    for (int x = 1; x < 6; x++) pix(x, 480, 1'b0);
    hsync(524);
    active(0, 0, 10);
    chk("sh_u0", tex_u, 16'd120);
    chk("sh_v0", tex_v, 16'd0);
    chk("sh_cnt", vcnt, 11);

    // one full active line: 640 pulses, last pixel 2*639+100
    hsync(0);
    vcnt = 0;
    active(1, 0, 639);
    chk("line_cnt", vcnt, 640);
    chk("line_u639", tex_u, 16'd1378);
    chk("line_v639", tex_v, 16'd0);

    // reset asserted at x=200, released at x=210
    hsync(19);
    active(20, 0, 200);
    reset = 1'b0;
    vcnt = 0;
    for (int x = 201; x < 210; x++) pix(x, 20, 1'b1);
    reset = 1'b1;
    for (int x = 210; x < 640; x++) pix(x, 20, 1'b1);
    chk("rstline_cnt", vcnt, 0);
    hsync(20);
    active(21, 0, 10);
    chk("rstnext_u", tex_u, 16'd10);
    chk("rstnext_v", tex_v, 16'd21);

    chk("valid_in_blank", bad_blank, 0);
    chk("valid_not_1clk", bad_gap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
